// File: rtl/dmem_resp_pkg.sv
// -----------------------------------------------------------------------------
// dmem_resp_pkg
// Shared definitions for the data-memory responder.
//
// Text macros (kept here so every file that imports the package sees them):
//   `RegBus          bus word range (31:0)
//   `ZeroWord        all-zero bus word
//   `DataMemNumLog2  default log2 word count of the data array
//   `ChipEnable / `ChipDisable
//   `DmemStIdle / `DmemStWait / `DmemStResp   FSM state encodings
//
// Package contents:
//   DATA_MEM_NUM_LOG2  default for the DEPTH_LOG2 parameter
//   ZERO_WORD          `ZeroWord as a typed constant
//   dmem_state_e       FSM state type (IDLE, WAIT, RESP)
//   addr_out_of_range  true when an address has bits set above the array
// -----------------------------------------------------------------------------
`ifndef DMEM_RESP_DEFINES
`define DMEM_RESP_DEFINES
`define RegBus          31:0
`define ZeroWord        32'h0000_0000
`define DataMemNumLog2  10
`define ChipEnable      1'b1
`define ChipDisable     1'b0
`define DmemStIdle      2'b00
`define DmemStWait      2'b01
`define DmemStResp      2'b10
`endif

package dmem_resp_pkg;

  localparam int DATA_MEM_NUM_LOG2 = `DataMemNumLog2;
  localparam logic [`RegBus] ZERO_WORD = `ZeroWord;

  typedef enum logic [1:0] {
    ST_IDLE = `DmemStIdle,
    ST_WAIT = `DmemStWait,
    ST_RESP = `DmemStResp
  } dmem_state_e;

  // The word index uses addr[depth_log2+1:2]; anything above that is a
  // reference outside the array.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input int depth_log2);
    return (addr >> (depth_log2 + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// -----------------------------------------------------------------------------
// dmem_resp_if
// Memory-stage data bus between an initiator (master) and dmem_resp (slave).
// Signal names carry the direction as seen from the responder.
//
//   req_i    access request
//   we_i     1 = store, 0 = load
//   addr_i   byte address
//   sel_i    byte-lane enables, bit i covers bits 8i+7:8i
//   wdata_i  store data
//   rdata_o  load data (zero unless ack_o is high on a good load)
//   ack_o    one-cycle completion strobe
//   err_o    error flag, meaningful only while ack_o is high
// -----------------------------------------------------------------------------
interface dmem_resp_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, sel_i, wdata_i,
    input  rdata_o, ack_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, sel_i, wdata_i,
    output rdata_o, ack_o, err_o
  );
endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Byte-lane data RAM: synchronous write per enabled lane, combinational read.
// Contents are never reset.
//
//   clk      clock
//   we_i     write strobe (qualified per lane by sel_i)
//   sel_i    byte-lane enables
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data (combinational)
// -----------------------------------------------------------------------------
module dmem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    sel_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  localparam int DEPTH = 1 << AW;

  // One narrow array per lane so a partial store touches only its lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];

      always_ff @(posedge clk) begin
        if (we_i && sel_i[gi]) begin
          mem_q[waddr_i] <= wdata_i[8*gi +: 8];
        end
      end

      assign rdata_o[8*gi +: 8] = mem_q[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Data-memory responder for a pipeline memory stage. Accepts one access in
// IDLE, optionally inserts wait states (WAIT), then acknowledges for exactly
// one cycle (RESP). Stores write the enabled byte lanes during RESP.
//
// Build option: define DMEM_WAIT_EN to insert WAIT_CYCLES wait states per
// access. Without it (or with WAIT_CYCLES=0) ack follows acceptance by one
// cycle and the wait counter is not built.
//
//   clk   clock
//   rst   asynchronous active-high reset (array contents untouched)
//   bus   dmem_resp_if.slave: req_i/we_i/addr_i/sel_i/wdata_i in,
//         rdata_o/ack_o/err_o out
// -----------------------------------------------------------------------------
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = DATA_MEM_NUM_LOG2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_resp_if.slave  bus
);

  dmem_state_e    state_q;
  logic           txn_we_q;
  logic [31:0]    txn_addr_q;
  logic [3:0]     txn_sel_q;
  logic [31:0]    txn_wdata_q;
  logic           ack_q;
  logic           err_q;
  logic [`RegBus] rdata_q;

  logic           accept;
  logic           skip_wait;
  logic           wait_done;

  logic           cur_we;
  logic [31:0]    cur_addr;
  logic [3:0]     cur_sel;
  logic           cur_err;
  logic [31:0]    ram_rdata;
  logic [31:0]    resp_rdata;
  logic           ram_we;

  assign accept = (state_q == ST_IDLE) && bus.req_i;

  // When responding straight out of IDLE the latched copy is not loaded yet,
  // so the response is computed from the live inputs; afterwards only the
  // latched copy is used, which makes later input changes irrelevant.
  always_comb begin
    cur_we   = txn_we_q;
    cur_addr = txn_addr_q;
    cur_sel  = txn_sel_q;
    if (state_q == ST_IDLE) begin
      cur_we   = bus.we_i;
      cur_addr = bus.addr_i;
      cur_sel  = bus.sel_i;
    end
  end

  assign cur_err    = addr_out_of_range(cur_addr, DEPTH_LOG2) ||
                      (cur_we && (cur_sel == 4'b0000));
  assign resp_rdata = (cur_we || cur_err) ? ZERO_WORD : ram_rdata;

  // The write lands at the end of RESP; a reset during RESP clears ack_q and
  // so cancels the write.
  assign ram_we = ack_q && txn_we_q && !err_q;

`ifdef DMEM_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt_q;

  assign skip_wait = (WAIT_CYCLES == 0);
  assign wait_done = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  assign skip_wait = 1'b1;
  assign wait_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      txn_we_q    <= 1'b0;
      txn_addr_q  <= 32'd0;
      txn_sel_q   <= 4'd0;
      txn_wdata_q <= 32'd0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= ZERO_WORD;
    end else begin
      // Response outputs are strobes: zero unless set below.
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= ZERO_WORD;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_i) begin
            txn_we_q    <= bus.we_i;
            txn_addr_q  <= bus.addr_i;
            txn_sel_q   <= bus.sel_i;
            txn_wdata_q <= bus.wdata_i;
            if (skip_wait) begin
              state_q <= ST_RESP;
              ack_q   <= 1'b1;
              err_q   <= cur_err;
              rdata_q <= resp_rdata;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            state_q <= ST_RESP;
            ack_q   <= 1'b1;
            err_q   <= cur_err;
            rdata_q <= resp_rdata;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .AW (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .sel_i   (txn_sel_q),
    .waddr_i (txn_addr_q[DEPTH_LOG2+1:2]),
    .wdata_i (txn_wdata_q),
    .raddr_i (cur_addr[DEPTH_LOG2+1:2]),
    .rdata_o (ram_rdata)
  );

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  localparam int WAIT = 2;
`ifdef DMEM_WAIT_EN
  localparam int LAT = WAIT + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  dmem_resp_if bus ();

  dmem_resp #(
    .DEPTH_LOG2  (10),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one access (called #1 after a rising edge with the DUT idle), drop
  // req and scramble the inputs right after acceptance, then check latency,
  // response, the one-cycle ack and the idle-zero rdata.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    logic [31:0] got_rdata;
    logic got_err;
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.sel_i   = sel;
    bus.wdata_i = wdata;
    @(posedge clk); #1;
    bus.req_i   = 1'b0;
    bus.we_i    = ~we;
    bus.addr_i  = 32'hFFFF_FFFF;
    bus.sel_i   = 4'b0000;
    bus.wdata_i = ~wdata;
    lat = 1;
    while (bus.ack_o !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got_rdata = bus.rdata_o;
    got_err   = bus.err_o;
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({tag, " rdata"}, got_rdata, exp_rdata);
    $display("%s we=%0b addr=0x%08h sel=%b wdata=0x%08h lat=%0d err=%0b rdata=0x%08h",
             tag, we, addr, sel, wdata, lat, got_err, got_rdata);
    @(posedge clk); #1;
    chk({tag, " ack one-cycle"}, {31'd0, bus.ack_o}, 32'd0);
    chk({tag, " rdata idle"}, bus.rdata_o, 32'd0);
  endtask

  initial begin
    int acks;
    int t;
    int first_ack;
    int second_ack;

    rst         = 1'b1;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = 32'd0;
    bus.sel_i   = 4'd0;
    bus.wdata_i = 32'd0;
    #2;
    chk("reset ack", {31'd0, bus.ack_o}, 32'd0);
    chk("reset err", {31'd0, bus.err_o}, 32'd0);
    chk("reset rdata", bus.rdata_o, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Load hit
    access("store_10", 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b0);
    access("load_10", 1'b0, 32'h0000_0010, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b0);
    access("load_13_lowbits", 1'b0, 32'h0000_0013, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // No second transaction after req dropped
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o === 1'b1) acks++;
    end
    chk("no extra ack after drop", acks, 0);

    // Byte lanes
    access("store_20_full", 1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'd0, 1'b0);
    access("store_20_0101", 1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 32'd0, 1'b0);
    access("load_20", 1'b0, 32'h0000_0020, 4'hF, 32'd0, 32'h11BB_33DD, 1'b0);

    // Highest valid word
    access("store_ffc", 1'b1, 32'h0000_0FFC, 4'hF, 32'h0BAD_F00D, 32'd0, 1'b0);
    access("load_ffc", 1'b0, 32'h0000_0FFC, 4'hF, 32'd0, 32'h0BAD_F00D, 1'b0);

    // Errors
    access("load_oor", 1'b0, 32'h0001_0000, 4'hF, 32'd0, 32'd0, 1'b1);
    access("store_sel0", 1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    access("reload_20", 1'b0, 32'h0000_0020, 4'hF, 32'd0, 32'h11BB_33DD, 1'b0);
    access("store_oor", 1'b1, 32'h0000_1010, 4'hF, 32'h5555_5555, 32'd0, 1'b1);
    access("reload_10", 1'b0, 32'h0000_0010, 4'hF, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // Latency and issue interval with req held high
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b0;
    bus.addr_i  = 32'h0000_0010;
    bus.sel_i   = 4'hF;
    bus.wdata_i = 32'd0;
    t = 0;
    first_ack = -1;
    second_ack = -1;
    while (second_ack < 0 && t < 30) begin
      @(posedge clk); #1;
      t++;
      if (bus.ack_o === 1'b1) begin
        if (first_ack < 0) first_ack = t;
        else second_ack = t;
      end
    end
    bus.req_i = 1'b0;
    chk("back-to-back first ack", first_ack, LAT);
    chk("back-to-back second ack", second_ack, 2 * LAT + 1);
    $display("back_to_back first_ack=%0d second_ack=%0d", first_ack, second_ack);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o === 1'b1) acks++;
    end
    chk("no ack after req low", acks, 0);

    // Reset mid-transaction aborts a store
    access("store_30", 1'b1, 32'h0000_0030, 4'hF, 32'h1234_5678, 32'd0, 1'b0);
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = 32'h0000_0030;
    bus.sel_i   = 4'hF;
    bus.wdata_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid reset ack", {31'd0, bus.ack_o}, 32'd0);
    chk("mid reset rdata", bus.rdata_o, 32'd0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o === 1'b1) acks++;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o === 1'b1) acks++;
    end
    chk("aborted store no ack", acks, 0);
    $display("reset_abort store addr=0x00000030 acks=%0d", acks);
    access("reload_30", 1'b0, 32'h0000_0030, 4'hF, 32'd0, 32'h1234_5678, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the word count of the data array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted per access (used only under DMEM_WAIT_EN).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_i  input  1  access request from the memory-stage initiator.
REQ-006 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr_i  input  32  byte address.
REQ-008 SHALL have port sel_i  input  4  byte-lane enables; bit i covers bits 8i+7:8i.
REQ-009 SHALL have port wdata_i  input  32 (`RegBus)  store data.
REQ-010 SHALL have port rdata_o  output  32 (`RegBus)  load data.
REQ-011 SHALL have port ack_o  output  1  one-cycle completion strobe.
REQ-012 SHALL have port err_o  output  1  error flag, valid only while ack_o=1.

Function
REQ-013 SHALL implement states IDLE, WAIT and RESP.
REQ-014 In IDLE with req_i=1, SHALL latch we_i, addr_i, sel_i and wdata_i, then go to WAIT, or to RESP when the wait count is 0.
REQ-015 WAIT SHALL decrement a counter loaded with WAIT_CYCLES-1, and SHALL go to RESP when the counter reaches 0.
REQ-016 RESP SHALL assert ack_o for exactly one cycle, then return to IDLE.
REQ-017 A new request SHALL NOT be accepted in the cycle ack_o is high; the minimum issue interval is WAIT_CYCLES+2 cycles.
REQ-018 Once latched, a transaction SHALL complete even if req_i drops; input changes after acceptance SHALL be ignored.
REQ-019 The word index SHALL be addr[DEPTH_LOG2+1:2]; addr[1:0] SHALL be ignored.
REQ-020 Error condition: err_o=1 if any address bit above DEPTH_LOG2+1 is nonzero, or if a store has sel_i=0.
REQ-021 On an error, no array write SHALL occur and rdata_o SHALL be `ZeroWord.
REQ-022 A store SHALL write only the enabled byte lanes, in the RESP cycle; rdata_o SHALL be `ZeroWord on a store ack.
REQ-023 A load SHALL return the full 32-bit word; rdata_o SHALL be valid while ack_o=1 and be `ZeroWord otherwise.
REQ-024 A load from a word stored earlier SHALL return the post-store value (no stale read).

Reset
REQ-025 rst=1 SHALL force the state to IDLE, ack_o=0, err_o=0, rdata_o=`ZeroWord and the counter to 0, asynchronously.
REQ-026 Reset mid-transaction SHALL abort it: no ack, and a pending store is not written.
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 With macro DMEM_WAIT_EN defined, SHALL insert WAIT_CYCLES wait states per REQ-014/015.
REQ-029 With WAIT_CYCLES=0, SHALL behave as the build without the macro.
REQ-030 Without DMEM_WAIT_EN, the WAIT state and counter SHALL be absent; IDLE SHALL go straight to RESP, giving ack 1 cycle after acceptance.

Structure
REQ-031 The shared defines file SHALL hold `RegBus, `ZeroWord, the state encodings, `DataMemNumLog2 (default for DEPTH_LOG2), and `ChipEnable/`ChipDisable.
REQ-032 SHALL instantiate one sub-module, dmem_array: a synchronous-write byte-lane RAM with a combinational read port, no reset.

Verification
REQ-033 Load hit: store 0xDEADBEEF to 0x10 with sel=4'hF, then load 0x10 -> ack with rdata=0xDEADBEEF, err=0.
REQ-034 Byte lanes: store 0x11223344 to 0x20 with sel=4'hF, then store 0xAABBCCDD with sel=4'b0101, then load -> 0x11BB33DD.
REQ-035 Latency and interval: with DMEM_WAIT_EN and WAIT_CYCLES=2, req held high continuously -> acks 3 cycles after each acceptance, spaced 4 cycles apart; without the macro -> ack 1 cycle after acceptance, spaced 2 cycles.
REQ-036 Errors: load at 0x0001_0000 (DEPTH_LOG2=10) -> ack, err=1, rdata=0; store with sel=0 -> err=1, and the target word is unchanged on reload.
REQ-037 Reset mid-operation: assert rst during WAIT of a store to 0x30 -> no ack; reload of 0x30 returns the prior value.
REQ-038 req_i dropped after acceptance -> ack still issued once, with no second transaction.
